// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath width, ALU/next-PC/writeback codes,
// the EX/MEM boundary record and the forwarding match helper.
package pipe_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [4:0] {
    ALU_NOP   = 5'd0,
    ALU_LUI   = 5'd1,
    ALU_AUIPC = 5'd2,
    ALU_ADD   = 5'd3,
    ALU_SUB   = 5'd4,
    ALU_BNE   = 5'd5,
    ALU_BLT   = 5'd6,
    ALU_BGE   = 5'd7,
    ALU_BLTU  = 5'd8,
    ALU_SLT   = 5'd9,
    ALU_SLTU  = 5'd10,
    ALU_XOR   = 5'd11,
    ALU_OR    = 5'd12,
    ALU_AND   = 5'd13,
    ALU_SLL   = 5'd14,
    ALU_SRL   = 5'd15,
    ALU_MUL   = 5'd16,
    ALU_SRA   = 5'd17,
    ALU_BGEU  = 5'd18,
    ALU_BEQ   = 5'd19
  } alu_op_e;

  typedef enum logic [2:0] {
    NPC_PC4    = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_JAL    = 3'b010,
    NPC_JALR   = 3'b100
  } npc_op_e;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_MEM = 2'd1,
    WD_PC  = 2'd2
  } wd_sel_e;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_DONE
  } mul_state_e;

  typedef struct packed {
    logic            reg_write;
    logic            mem_w;
    logic            ltype;
    logic [2:0]      dm_ctrl;
    logic [1:0]      wd_sel;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pc4;
  } ex_mem_t;

  // x0 is never a forwarding source, whatever the producer claims.
  function automatic logic fwd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX input fields and EX/MEM output fields of the execute stage.
// master: the surrounding pipeline; slave: exe_stage.
interface exe_stage_if import pipe_pkg::*; ();

    logic            i_exe_RegWrite;
    logic            i_exe_mem_w;
    logic            i_exe_ALUSrc;
    logic            i_exe_ltype;
    logic [4:0]      i_exe_ALUOp;
    logic [2:0]      i_exe_dm_ctrl;
    logic [1:0]      i_exe_WDSel;
    logic [2:0]      i_exe_NPCOp;
    logic [XLEN-1:0] i_exe_pc;
    logic [XLEN-1:0] i_exe_RD1;
    logic [XLEN-1:0] i_exe_RD2;
    logic [XLEN-1:0] i_exe_immout;
    logic [4:0]      i_exe_rd;
    logic [4:0]      i_exe_rs1;
    logic [4:0]      i_exe_rs2;

    logic            o_mem_RegWrite;
    logic            o_mem_mem_w;
    logic            o_mem_ltype;
    logic [2:0]      o_mem_dm_ctrl;
    logic [1:0]      o_mem_WDSel;
    logic [4:0]      o_mem_rd;
    logic [XLEN-1:0] o_mem_alu_result;
    logic [XLEN-1:0] o_mem_store_data;
    logic [XLEN-1:0] o_mem_pc4;

    modport master (
        output i_exe_RegWrite, i_exe_mem_w, i_exe_ALUSrc, i_exe_ltype, i_exe_ALUOp,
               i_exe_dm_ctrl, i_exe_WDSel, i_exe_NPCOp, i_exe_pc, i_exe_RD1, i_exe_RD2,
               i_exe_immout, i_exe_rd, i_exe_rs1, i_exe_rs2,
        input  o_mem_RegWrite, o_mem_mem_w, o_mem_ltype, o_mem_dm_ctrl, o_mem_WDSel,
               o_mem_rd, o_mem_alu_result, o_mem_store_data, o_mem_pc4
    );

    modport slave (
        input  i_exe_RegWrite, i_exe_mem_w, i_exe_ALUSrc, i_exe_ltype, i_exe_ALUOp,
               i_exe_dm_ctrl, i_exe_WDSel, i_exe_NPCOp, i_exe_pc, i_exe_RD1, i_exe_RD2,
               i_exe_immout, i_exe_rd, i_exe_rs1, i_exe_rs2,
        output o_mem_RegWrite, o_mem_mem_w, o_mem_ltype, o_mem_dm_ctrl, o_mem_WDSel,
               o_mem_rd, o_mem_alu_result, o_mem_store_data, o_mem_pc4
    );

endinterface

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per RUN cycle, result
// presented in DONE. Operands are sampled only when leaving IDLE.
module exe_mul_iter import pipe_pkg::*; #(
    parameter int unsigned WIDTH    = XLEN,
    parameter int unsigned MUL_ITER = XLEN
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;

    mul_state_e     state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state <= MUL_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (flush) begin
            state <= MUL_IDLE;
        end else begin
            case (state)
                MUL_IDLE: if (start) begin
                    a_q   <= op_a;
                    b_q   <= op_b;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= MUL_RUN;
                end
                MUL_RUN: begin
                    if (b_q[0]) acc <= acc + a_q;
                    a_q <= a_q << 1;
                    b_q <= b_q >> 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(MUL_ITER - 1)) state <= MUL_DONE;
                end
                MUL_DONE: state <= MUL_IDLE;
                default:  state <= MUL_IDLE;
            endcase
        end
    end

    // Reset and flush both release the front end in the same cycle they arrive.
    assign busy   = !resetn && !flush && (((state == MUL_IDLE) && start) || (state == MUL_RUN));
    assign done   = (state == MUL_DONE);
    assign result = acc;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: MEM/WB forwarding, single-cycle ALU, branch/jump redirect,
// iterative multiplier, and the EX/MEM boundary register.
module exe_stage import pipe_pkg::*; #(
    parameter int unsigned MUL_ITER = XLEN
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    exe_stage_if.slave      bus,
    input  logic            i_mem_RegWrite,
    input  logic [4:0]      i_mem_rd,
    input  logic [XLEN-1:0] i_mem_fwd,
    input  logic            i_wb_RegWrite,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_wdata,
    output logic            o_busy,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc
);

    alu_op_e         op;
    logic [XLEN-1:0] rs1_val, rs2_val, alu_b, alu_y, mul_y;
    logic            lt_s, lt_u, mul_done, redirect_raw;
    ex_mem_t         ex_mem_q;

    assign op = alu_op_e'(bus.i_exe_ALUOp);

    always_comb begin
        rs1_val = bus.i_exe_RD1;
        if (fwd_hit(i_mem_RegWrite, i_mem_rd, bus.i_exe_rs1))    rs1_val = i_mem_fwd;
        else if (fwd_hit(i_wb_RegWrite, i_wb_rd, bus.i_exe_rs1)) rs1_val = i_wb_wdata;
        rs2_val = bus.i_exe_RD2;
        if (fwd_hit(i_mem_RegWrite, i_mem_rd, bus.i_exe_rs2))    rs2_val = i_mem_fwd;
        else if (fwd_hit(i_wb_RegWrite, i_wb_rd, bus.i_exe_rs2)) rs2_val = i_wb_wdata;
    end

    assign alu_b = bus.i_exe_ALUSrc ? bus.i_exe_immout : rs2_val;
    assign lt_s  = $signed(rs1_val) < $signed(alu_b);
    assign lt_u  = rs1_val < alu_b;

    always_comb begin
        alu_y = '0;
        case (op)
            ALU_LUI:   alu_y = alu_b;
            ALU_AUIPC: alu_y = bus.i_exe_pc + alu_b;
            ALU_ADD:   alu_y = rs1_val + alu_b;
            ALU_SUB:   alu_y = rs1_val - alu_b;
            ALU_BEQ:   alu_y = XLEN'(rs1_val == alu_b);
            ALU_BNE:   alu_y = XLEN'(rs1_val != alu_b);
            ALU_BLT,
            ALU_SLT:   alu_y = XLEN'(lt_s);
            ALU_BGE:   alu_y = XLEN'(!lt_s);
            ALU_BLTU,
            ALU_SLTU:  alu_y = XLEN'(lt_u);
            ALU_BGEU:  alu_y = XLEN'(!lt_u);
            ALU_XOR:   alu_y = rs1_val ^ alu_b;
            ALU_OR:    alu_y = rs1_val | alu_b;
            ALU_AND:   alu_y = rs1_val & alu_b;
            ALU_SLL:   alu_y = rs1_val << alu_b[4:0];
            ALU_SRL:   alu_y = rs1_val >> alu_b[4:0];
            ALU_SRA:   alu_y = $signed(rs1_val) >>> alu_b[4:0];
            default:   alu_y = '0;
        endcase
    end

    always_comb begin
        redirect_raw  = 1'b0;
        o_redirect_pc = bus.i_exe_pc + bus.i_exe_immout;
        case (npc_op_e'(bus.i_exe_NPCOp))
            NPC_BRANCH: redirect_raw = |alu_y;
            NPC_JAL:    redirect_raw = 1'b1;
            NPC_JALR: begin
                redirect_raw  = 1'b1;
                o_redirect_pc = (rs1_val + bus.i_exe_immout) & ~XLEN'(1);
            end
            default: redirect_raw = 1'b0;
        endcase
    end

    assign o_redirect = redirect_raw && !flush && !o_busy;

    exe_mul_iter #(
        .WIDTH    (XLEN),
        .MUL_ITER (MUL_ITER)
    ) u_mul (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .start  (op == ALU_MUL),
        .op_a   (rs1_val),
        .op_b   (rs2_val),
        .busy   (o_busy),
        .done   (mul_done),
        .result (mul_y)
    );

    // ID/EX is held during a multiply, so DONE still sees the MUL's own control fields.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            ex_mem_q <= '0;
        end else if (flush || o_busy) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q.reg_write  <= bus.i_exe_RegWrite;
            ex_mem_q.mem_w      <= bus.i_exe_mem_w;
            ex_mem_q.ltype      <= bus.i_exe_ltype;
            ex_mem_q.dm_ctrl    <= bus.i_exe_dm_ctrl;
            ex_mem_q.wd_sel     <= bus.i_exe_WDSel;
            ex_mem_q.rd         <= bus.i_exe_rd;
            ex_mem_q.alu_result <= mul_done ? mul_y : alu_y;
            ex_mem_q.store_data <= rs2_val;
            ex_mem_q.pc4        <= bus.i_exe_pc + XLEN'(4);
        end
    end

    assign bus.o_mem_RegWrite   = ex_mem_q.reg_write;
    assign bus.o_mem_mem_w      = ex_mem_q.mem_w;
    assign bus.o_mem_ltype      = ex_mem_q.ltype;
    assign bus.o_mem_dm_ctrl    = ex_mem_q.dm_ctrl;
    assign bus.o_mem_WDSel      = ex_mem_q.wd_sel;
    assign bus.o_mem_rd         = ex_mem_q.rd;
    assign bus.o_mem_alu_result = ex_mem_q.alu_result;
    assign bus.o_mem_store_data = ex_mem_q.store_data;
    assign bus.o_mem_pc4        = ex_mem_q.pc4;

endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage: forwarding, ALU, redirect, multiplier,
// flush abort and asynchronous reset, all against hand-computed values.
module tb_exe_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        i_mem_RegWrite;
    logic [4:0]  i_mem_rd;
    logic [31:0] i_mem_fwd;
    logic        i_wb_RegWrite;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_wdata;
    logic        o_busy;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;

    int checks = 0;
    int errors = 0;

    exe_stage_if bus ();

    exe_stage #(.MUL_ITER(32)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .bus            (bus),
        .i_mem_RegWrite (i_mem_RegWrite),
        .i_mem_rd       (i_mem_rd),
        .i_mem_fwd      (i_mem_fwd),
        .i_wb_RegWrite  (i_wb_RegWrite),
        .i_wb_rd        (i_wb_rd),
        .i_wb_wdata     (i_wb_wdata),
        .o_busy         (o_busy),
        .o_redirect     (o_redirect),
        .o_redirect_pc  (o_redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_idex();
        bus.i_exe_RegWrite = 1'b0;
        bus.i_exe_mem_w    = 1'b0;
        bus.i_exe_ALUSrc   = 1'b0;
        bus.i_exe_ltype    = 1'b0;
        bus.i_exe_ALUOp    = ALU_NOP;
        bus.i_exe_dm_ctrl  = 3'd0;
        bus.i_exe_WDSel    = WD_ALU;
        bus.i_exe_NPCOp    = NPC_PC4;
        bus.i_exe_pc       = 32'h0;
        bus.i_exe_RD1      = 32'h0;
        bus.i_exe_RD2      = 32'h0;
        bus.i_exe_immout   = 32'h0;
        bus.i_exe_rd       = 5'd0;
        bus.i_exe_rs1      = 5'd0;
        bus.i_exe_rs2      = 5'd0;
        i_mem_RegWrite     = 1'b0;
        i_mem_rd           = 5'd0;
        i_mem_fwd          = 32'h0;
        i_wb_RegWrite      = 1'b0;
        i_wb_rd            = 5'd0;
        i_wb_wdata         = 32'h0;
        flush              = 1'b0;
    endtask

    task automatic drive_mul(input logic [31:0] a, input logic [31:0] b);
        clear_idex();
        bus.i_exe_ALUOp    = ALU_MUL;
        bus.i_exe_RegWrite = 1'b1;
        bus.i_exe_rd       = 5'd9;
        bus.i_exe_rs1      = 5'd1;
        bus.i_exe_rs2      = 5'd2;
        bus.i_exe_RD1      = a;
        bus.i_exe_RD2      = b;
    endtask

    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int busy_cycles;
        int dirty;
        busy_cycles = 0;
        dirty       = 0;
        drive_mul(a, b);
        #1;
        for (int i = 0; i < 60; i++) begin
            if (!o_busy) break;
            busy_cycles++;
            tick();
            if (bus.o_mem_RegWrite || bus.o_mem_alu_result != 32'h0 || bus.o_mem_rd != 5'd0)
                dirty++;
        end
        check({tag, "_busy_cycles"}, busy_cycles, 33);
        check({tag, "_bubbles"}, dirty, 0);
        tick();
        check({tag, "_result"}, bus.o_mem_alu_result, exp);
        check({tag, "_rd"}, bus.o_mem_rd, 32'd9);
        check({tag, "_regwrite"}, bus.o_mem_RegWrite, 1);
        clear_idex();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int dirty;
        clear_idex();
        resetn = 1'b1;
        #2;
        check("rst_regwrite", bus.o_mem_RegWrite, 0);
        check("rst_alu", bus.o_mem_alu_result, 0);
        check("rst_busy", o_busy, 0);

        // reset dominates a live ADD across an edge
        bus.i_exe_ALUOp = ALU_ADD; bus.i_exe_RD1 = 32'h1; bus.i_exe_RD2 = 32'h2;
        bus.i_exe_RegWrite = 1'b1; bus.i_exe_rd = 5'd3; bus.i_exe_pc = 32'h10;
        tick();
        check("rst_hold_alu", bus.o_mem_alu_result, 0);
        check("rst_hold_pc4", bus.o_mem_pc4, 0);
        resetn = 1'b0;

        // forwarding priority: MEM beats WB
        clear_idex();
        bus.i_exe_ALUOp = ALU_ADD; bus.i_exe_RegWrite = 1'b1; bus.i_exe_rd = 5'd7;
        bus.i_exe_rs1 = 5'd5; bus.i_exe_RD1 = 32'h99; bus.i_exe_rs2 = 5'd2; bus.i_exe_RD2 = 32'h1;
        bus.i_exe_pc = 32'h40;
        i_mem_RegWrite = 1'b1; i_mem_rd = 5'd5; i_mem_fwd = 32'h11;
        i_wb_RegWrite = 1'b1; i_wb_rd = 5'd5; i_wb_wdata = 32'h22;
        tick();
        check("fwd_mem_prio", bus.o_mem_alu_result, 32'h12);
        check("fwd_rd", bus.o_mem_rd, 32'd7);
        check("fwd_pc4", bus.o_mem_pc4, 32'h44);

        i_mem_RegWrite = 1'b0;
        tick();
        check("fwd_wb_only", bus.o_mem_alu_result, 32'h23);

        // x0 is never forwarded
        clear_idex();
        bus.i_exe_ALUOp = ALU_ADD; bus.i_exe_ALUSrc = 1'b1; bus.i_exe_immout = 32'h8;
        i_mem_RegWrite = 1'b1; i_mem_rd = 5'd0; i_mem_fwd = 32'hDEADBEEF;
        i_wb_RegWrite = 1'b1; i_wb_rd = 5'd0; i_wb_wdata = 32'h1234;
        tick();
        check("x0_alu", bus.o_mem_alu_result, 32'h8);
        check("x0_store", bus.o_mem_store_data, 32'h0);

        // store data takes forwarded rs2 even when ALUSrc selects the immediate
        clear_idex();
        bus.i_exe_ALUOp = ALU_ADD; bus.i_exe_ALUSrc = 1'b1; bus.i_exe_immout = 32'h4;
        bus.i_exe_mem_w = 1'b1; bus.i_exe_rs1 = 5'd1; bus.i_exe_RD1 = 32'h100;
        bus.i_exe_rs2 = 5'd3; bus.i_exe_RD2 = 32'h77;
        i_wb_RegWrite = 1'b1; i_wb_rd = 5'd3; i_wb_wdata = 32'h22;
        tick();
        check("st_addr", bus.o_mem_alu_result, 32'h104);
        check("st_data", bus.o_mem_store_data, 32'h22);
        check("st_mem_w", bus.o_mem_mem_w, 1);

        // SRA uses only the low five bits of operand B
        clear_idex();
        bus.i_exe_ALUOp = ALU_SRA; bus.i_exe_ALUSrc = 1'b1; bus.i_exe_immout = 32'h24;
        bus.i_exe_rs1 = 5'd1; bus.i_exe_RD1 = 32'h80000000;
        tick();
        check("sra_shamt", bus.o_mem_alu_result, 32'hF8000000);

        clear_idex();
        bus.i_exe_ALUOp = ALU_SLTU; bus.i_exe_rs1 = 5'd1; bus.i_exe_RD1 = 32'h1;
        bus.i_exe_rs2 = 5'd2; bus.i_exe_RD2 = 32'hFFFFFFFF;
        tick();
        check("sltu", bus.o_mem_alu_result, 32'h1);
        bus.i_exe_ALUOp = ALU_SLT;
        tick();
        check("slt_signed", bus.o_mem_alu_result, 32'h0);

        // taken branch, then the same branch flushed
        clear_idex();
        bus.i_exe_NPCOp = NPC_BRANCH; bus.i_exe_ALUOp = ALU_SLT;
        bus.i_exe_pc = 32'h100; bus.i_exe_immout = 32'h20;
        bus.i_exe_rs1 = 5'd1; bus.i_exe_RD1 = 32'h1; bus.i_exe_rs2 = 5'd2; bus.i_exe_RD2 = 32'h2;
        #1;
        check("br_taken", o_redirect, 1);
        check("br_target", o_redirect_pc, 32'h120);
        tick();
        check("br_pc4", bus.o_mem_pc4, 32'h104);
        flush = 1'b1;
        #1;
        check("br_flush_redirect", o_redirect, 0);
        tick();
        check("br_flush_alu", bus.o_mem_alu_result, 0);
        check("br_flush_pc4", bus.o_mem_pc4, 0);
        flush = 1'b0;
        bus.i_exe_RD1 = 32'h3;
        #1;
        check("br_not_taken", o_redirect, 0);

        clear_idex();
        bus.i_exe_NPCOp = NPC_JAL; bus.i_exe_pc = 32'h200; bus.i_exe_immout = 32'hFFFFFFF8;
        #1;
        check("jal_redirect", o_redirect, 1);
        check("jal_target", o_redirect_pc, 32'h1F8);
        bus.i_exe_NPCOp = NPC_JALR; bus.i_exe_rs1 = 5'd6; bus.i_exe_RD1 = 32'h0;
        bus.i_exe_immout = 32'h10;
        i_mem_RegWrite = 1'b1; i_mem_rd = 5'd6; i_mem_fwd = 32'h1001;
        #1;
        check("jalr_target", o_redirect_pc, 32'h1010);
        tick();

        run_mul("mul_neg", 32'h7, 32'hFFFFFFFF, 32'hFFFFFFF9);

        // flush and MUL together in IDLE: nothing starts
        drive_mul(32'h3, 32'h5);
        flush = 1'b1;
        #1;
        check("flush_mul_busy", o_busy, 0);
        tick();
        check("flush_mul_bubble", bus.o_mem_RegWrite, 0);
        clear_idex();
        #1;
        check("flush_mul_idle", o_busy, 0);
        tick();

        // abort in the 10th RUN cycle
        drive_mul(32'h3, 32'h5);
        for (int i = 0; i < 10; i++) tick();
        check("abort_pre_busy", o_busy, 1);
        flush = 1'b1;
        #1;
        check("abort_busy_drop", o_busy, 0);
        tick();
        check("abort_bubble", bus.o_mem_RegWrite, 0);
        clear_idex();
        bus.i_exe_ALUOp = ALU_ADD; bus.i_exe_RegWrite = 1'b1; bus.i_exe_rd = 5'd4;
        bus.i_exe_rs1 = 5'd1; bus.i_exe_RD1 = 32'h10; bus.i_exe_rs2 = 5'd2; bus.i_exe_RD2 = 32'h5;
        #1;
        check("abort_idle", o_busy, 0);
        tick();
        check("abort_add_result", bus.o_mem_alu_result, 32'h15);
        check("abort_add_rd", bus.o_mem_rd, 32'd4);
        clear_idex();
        dirty = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.o_mem_RegWrite || o_busy) dirty++;
        end
        check("abort_no_writeback", dirty, 0);

        // asynchronous reset mid-RUN
        drive_mul(32'h6, 32'h7);
        for (int i = 0; i < 5; i++) tick();
        check("rst_run_pre_busy", o_busy, 1);
        resetn = 1'b1;
        #1;
        check("rst_run_busy", o_busy, 0);
        check("rst_run_alu", bus.o_mem_alu_result, 0);
        check("rst_run_redirect", o_redirect, 0);
        tick();
        check("rst_run_hold_busy", o_busy, 0);
        check("rst_run_hold_rw", bus.o_mem_RegWrite, 0);
        resetn = 1'b0;

        run_mul("mul_after_rst", 32'h3, 32'h5, 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
